multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have parameter OPCODE_W, default 8, opcode width.
REQ-002 SHALL have parameter MULT_CYCLES, default 4, total MULT latency in cycles (1..15).
REQ-003 SHALL have parameter MEM_TIMEOUT, default 255, maximum BUSYWAIT cycles before abort (1..255).
REQ-004 SHALL have ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous active-low reset.
- OPCODE  in  OPCODE_W  current instruction opcode.
- INSTR_VALID  in  1  OPCODE valid this cycle.
- BUSYWAIT  in  1  data memory busy.
- WRITEENABLE  out  1  register file write.
- ALUSRC  out  1  0 = immediate, 1 = register.
- ALUOP  out  3  ALU select.
- NEMUX  out  1  negate second operand.
- BRANCH  out  2  00 = seq, 01 = jump, 10 = BEQ, 11 = BNE.
- MEMREAD  out  1  data memory read.
- MEMWRITE  out  1  data memory write.
- MEMTOREG  out  1  write-back from memory.
- STALL  out  1  hold PC and instruction register.
- ILLEGAL  out  1  sticky: undefined opcode seen.
- MEMERR  out  1  sticky: memory timeout.

Function
REQ-005 SHALL decode these opcodes as (WE, ALUOP, ALUSRC, NEMUX, BRANCH): ADD 0x00 = 1,001,1,0,00; SUB 0x01 = 1,001,1,1,00; AND 0x02 = 1,010,1,0,00; OR 0x03 = 1,011,1,0,00; MOV 0x04 = 1,000,1,0,00; LOADI 0x05 = 1,000,0,0,00; J 0x06 = 0,000,0,0,01; BEQ 0x07 = 0,001,1,1,10; BNE 0x08 = 0,001,1,1,11; MULT 0x09 = 1,100,1,0,00; SL 0x0A = 1,101,0,0,00; SRA 0x0C = 1,110,0,0,00; ROR 0x0D = 1,111,0,0,00.
REQ-006 SHALL decode the memory opcodes LWD 0x0E, LWI 0x0F, SWD 0x10, SWI 0x11; direct forms set ALUSRC=1, immediate forms set ALUSRC=0; all four set ALUOP=000.
REQ-007 SHALL implement states RUN, MULT and MEM, with RUN following reset.
REQ-008 In RUN, outputs SHALL decode combinationally from OPCODE and the opcode SHALL latch into an internal register on every cycle where INSTR_VALID=1.
REQ-009 In MULT and MEM, outputs SHALL decode from the latched opcode; OPCODE and INSTR_VALID SHALL be ignored.
REQ-010 With INSTR_VALID=0 in RUN, all outputs except the sticky flags SHALL be 0.
REQ-011 MULT issue with MULT_CYCLES=1 SHALL complete in one cycle with WE=1 and STALL=0.
REQ-012 MULT issue with MULT_CYCLES>1:
- Issue cycle: STALL=1, WE=0, counter loads MULT_CYCLES-2, next state MULT.
- MULT: STALL=1 and WE=0 while counter≠0, counter decrements each cycle.
- MULT with counter=0: WE=1, STALL=0, next state RUN.
REQ-013 Load/store issue in RUN:
- Drives MEMREAD (loads) or MEMWRITE (stores), STALL=1, WE=0, timeout counter cleared, next state MEM.
REQ-014 In MEM, MEMREAD or MEMWRITE SHALL stay asserted while BUSYWAIT=1, with STALL=1 and the timeout counter incrementing.
REQ-015 MEM completion when BUSYWAIT=0:
- MEMREAD=MEMWRITE=0, STALL=0, next state RUN.
- Loads additionally drive WE=1 and MEMTOREG=1 in the completion cycle.
- Stores drive WE=0.
REQ-016 MEM timeout, when the counter reaches MEM_TIMEOUT with BUSYWAIT=1:
- Next cycle: MEMERR←1, WE=0, STALL=0, next state RUN.
REQ-017 An undefined opcode with INSTR_VALID=1 SHALL set ILLEGAL←1 at the next edge and drive all other outputs 0 (NOP).
REQ-018 ILLEGAL and MEMERR SHALL clear only on reset.
REQ-019 J, BEQ and BNE SHALL be single-cycle and never assert STALL.
REQ-020 MEMTOREG SHALL be 0 in every cycle except a load completion cycle.

Reset
REQ-021 RESET=0 sampled at a CLK edge SHALL force: state RUN, counters 0, latched opcode 0x00, ILLEGAL=0, MEMERR=0.
REQ-022 While RESET=0, all outputs SHALL be driven 0, including STALL, MEMREAD and MEMWRITE.
REQ-023 Reset during MULT or MEM SHALL abort the operation without asserting WE.

Verification
REQ-024 MULTI_CYCLE_MULT: MULT_CYCLES=4, OPCODE=0x09 valid → STALL=1 for 3 cycles, WE=1 in the 4th cycle only, ALUOP=100 throughout.
REQ-025 LOAD_WAIT: LWD with BUSYWAIT high for 5 cycles → MEMREAD=1 for 6 cycles, STALL=1 for 6 cycles, one cycle of WE=1 and MEMTOREG=1, then RUN.
REQ-026 STORE_TIMEOUT: MEM_TIMEOUT=8, SWI with BUSYWAIT stuck at 1 → MEMERR=1 after 9 MEM cycles, WE never asserted, STALL then 0.
REQ-027 ILLEGAL_OP: OPCODE=0x0B valid → all controls 0 and ILLEGAL=1 next cycle; a following ADD decodes normally and ILLEGAL stays 1.
REQ-028 RESET_MID_OP: RESET=0 on the 2nd MULT cycle → next cycle state RUN, all outputs 0, no WE pulse.
REQ-029 BRANCH_DECODE: BEQ then BNE back-to-back → BRANCH 10 then 11, NEMUX=1, STALL=0 in both cycles.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: decodes the instruction opcode into datapath
// controls and sequences the two multicycle operations, a fixed-latency
// multiply and a handshaked data-memory access with a timeout abort.
// Sticky ILLEGAL/MEMERR flags report undefined opcodes and memory timeouts.
module multicycle_control_unit #(
    parameter int OPCODE_W    = 8,
    parameter int MULT_CYCLES = 4,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [OPCODE_W-1:0] OPCODE,
    input  logic                INSTR_VALID,
    input  logic                BUSYWAIT,
    output logic                WRITEENABLE,
    output logic                ALUSRC,
    output logic [2:0]          ALUOP,
    output logic                NEMUX,
    output logic [1:0]          BRANCH,
    output logic                MEMREAD,
    output logic                MEMWRITE,
    output logic                MEMTOREG,
    output logic                STALL,
    output logic                ILLEGAL,
    output logic                MEMERR
);

    // Opcode map
    localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(8'h00);
    localparam logic [OPCODE_W-1:0] OP_SUB   = OPCODE_W'(8'h01);
    localparam logic [OPCODE_W-1:0] OP_AND   = OPCODE_W'(8'h02);
    localparam logic [OPCODE_W-1:0] OP_OR    = OPCODE_W'(8'h03);
    localparam logic [OPCODE_W-1:0] OP_MOV   = OPCODE_W'(8'h04);
    localparam logic [OPCODE_W-1:0] OP_LOADI = OPCODE_W'(8'h05);
    localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(8'h06);
    localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(8'h07);
    localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(8'h08);
    localparam logic [OPCODE_W-1:0] OP_MULT  = OPCODE_W'(8'h09);
    localparam logic [OPCODE_W-1:0] OP_SL    = OPCODE_W'(8'h0A);
    localparam logic [OPCODE_W-1:0] OP_SRA   = OPCODE_W'(8'h0C);
    localparam logic [OPCODE_W-1:0] OP_ROR   = OPCODE_W'(8'h0D);
    localparam logic [OPCODE_W-1:0] OP_LWD   = OPCODE_W'(8'h0E);
    localparam logic [OPCODE_W-1:0] OP_LWI   = OPCODE_W'(8'h0F);
    localparam logic [OPCODE_W-1:0] OP_SWD   = OPCODE_W'(8'h10);
    localparam logic [OPCODE_W-1:0] OP_SWI   = OPCODE_W'(8'h11);

    // The issue cycle is the first multiply cycle, so the MULT state counts
    // down from MULT_CYCLES-2 and finishes on zero.
    localparam bit             MULT_MULTI = (MULT_CYCLES > 1);
    localparam logic [3:0]     MULT_LOAD  = MULT_MULTI ? 4'(MULT_CYCLES - 2) : 4'd0;
    localparam logic [7:0]     MEM_LIMIT  = 8'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_MULT = 2'd1,
        ST_MEM  = 2'd2
    } state_t;

    typedef struct packed {
        logic       legal;
        logic       we;
        logic       alusrc;
        logic [2:0] aluop;
        logic       nemux;
        logic [1:0] branch;
        logic       is_mult;
        logic       is_load;
        logic       is_store;
    } decode_t;

    // Static field decode of one opcode; sequencing is applied by the FSM.
    function automatic decode_t decode(input logic [OPCODE_W-1:0] op);
        decode_t d;
        d       = '0;
        d.legal = 1'b1;
        case (op)
            OP_ADD:   begin d.we = 1'b1; d.aluop = 3'b001; d.alusrc = 1'b1; end
            OP_SUB:   begin d.we = 1'b1; d.aluop = 3'b001; d.alusrc = 1'b1; d.nemux = 1'b1; end
            OP_AND:   begin d.we = 1'b1; d.aluop = 3'b010; d.alusrc = 1'b1; end
            OP_OR:    begin d.we = 1'b1; d.aluop = 3'b011; d.alusrc = 1'b1; end
            OP_MOV:   begin d.we = 1'b1; d.aluop = 3'b000; d.alusrc = 1'b1; end
            OP_LOADI: begin d.we = 1'b1; d.aluop = 3'b000; d.alusrc = 1'b0; end
            OP_J:     begin d.branch = 2'b01; end
            OP_BEQ:   begin d.aluop = 3'b001; d.alusrc = 1'b1; d.nemux = 1'b1; d.branch = 2'b10; end
            OP_BNE:   begin d.aluop = 3'b001; d.alusrc = 1'b1; d.nemux = 1'b1; d.branch = 2'b11; end
            OP_MULT:  begin d.we = 1'b1; d.aluop = 3'b100; d.alusrc = 1'b1; d.is_mult = 1'b1; end
            OP_SL:    begin d.we = 1'b1; d.aluop = 3'b101; end
            OP_SRA:   begin d.we = 1'b1; d.aluop = 3'b110; end
            OP_ROR:   begin d.we = 1'b1; d.aluop = 3'b111; end
            OP_LWD:   begin d.alusrc = 1'b1; d.is_load  = 1'b1; end
            OP_LWI:   begin d.alusrc = 1'b0; d.is_load  = 1'b1; end
            OP_SWD:   begin d.alusrc = 1'b1; d.is_store = 1'b1; end
            OP_SWI:   begin d.alusrc = 1'b0; d.is_store = 1'b1; end
            default:  d.legal = 1'b0;
        endcase
        return d;
    endfunction

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    logic [3:0]          mult_cnt_q, mult_cnt_d;
    logic [7:0]          mem_cnt_q, mem_cnt_d;
    logic                illegal_q, illegal_d;
    logic                memerr_q, memerr_d;
    decode_t             dec;

    // State, counters, latched opcode and sticky flags; synchronous reset.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values of the others, independent of statement order.
        if (!RESET) begin
            state_q    <= ST_RUN;
            opcode_q   <= '0;
            mult_cnt_q <= '0;
            mem_cnt_q  <= '0;
            illegal_q  <= 1'b0;
            memerr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            mult_cnt_q <= mult_cnt_d;
            mem_cnt_q  <= mem_cnt_d;
            illegal_q  <= illegal_d;
            memerr_q   <= memerr_d;
        end
    end

    // Next-state logic and control outputs; RUN decodes the live opcode,
    // MULT/MEM decode the opcode captured at issue.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        opcode_d    = opcode_q;
        mult_cnt_d  = mult_cnt_q;
        mem_cnt_d   = mem_cnt_q;
        illegal_d   = illegal_q;
        memerr_d    = memerr_q;
        WRITEENABLE = 1'b0;
        ALUSRC      = 1'b0;
        ALUOP       = 3'b000;
        NEMUX       = 1'b0;
        BRANCH      = 2'b00;
        MEMREAD     = 1'b0;
        MEMWRITE    = 1'b0;
        MEMTOREG    = 1'b0;
        STALL       = 1'b0;
        ILLEGAL     = illegal_q;
        MEMERR      = memerr_q;

        dec = decode((state_q == ST_RUN) ? OPCODE : opcode_q);

        case (state_q)
            ST_RUN: begin
                if (INSTR_VALID) begin
                    opcode_d = OPCODE;
                    if (!dec.legal) begin
                        // Undefined opcode executes as a NOP and is flagged.
                        illegal_d = 1'b1;
                    end else begin
                        WRITEENABLE = dec.we;
                        ALUSRC      = dec.alusrc;
                        ALUOP       = dec.aluop;
                        NEMUX       = dec.nemux;
                        BRANCH      = dec.branch;
                        if (dec.is_mult && MULT_MULTI) begin
                            WRITEENABLE = 1'b0;
                            STALL       = 1'b1;
                            mult_cnt_d  = MULT_LOAD;
                            state_d     = ST_MULT;
                        end else if (dec.is_load || dec.is_store) begin
                            MEMREAD   = dec.is_load;
                            MEMWRITE  = dec.is_store;
                            STALL     = 1'b1;
                            mem_cnt_d = '0;
                            state_d   = ST_MEM;
                        end
                    end
                end
            end

            ST_MULT: begin
                ALUSRC = dec.alusrc;
                ALUOP  = dec.aluop;
                if (mult_cnt_q != 4'd0) begin
                    STALL      = 1'b1;
                    mult_cnt_d = mult_cnt_q - 4'd1;
                end else begin
                    WRITEENABLE = 1'b1;
                    state_d     = ST_RUN;
                end
            end

            ST_MEM: begin
                ALUSRC = dec.alusrc;
                ALUOP  = dec.aluop;
                if (BUSYWAIT) begin
                    // Keep the request up while memory is busy; once the
                    // wait has lasted MEM_LIMIT counts, give up at this edge.
                    MEMREAD  = dec.is_load;
                    MEMWRITE = dec.is_store;
                    STALL    = 1'b1;
                    if (mem_cnt_q == MEM_LIMIT) begin
                        memerr_d  = 1'b1;
                        mem_cnt_d = '0;
                        state_d   = ST_RUN;
                    end else begin
                        mem_cnt_d = mem_cnt_q + 8'd1;
                    end
                end else begin
                    // Completion: loads write back the memory data.
                    WRITEENABLE = dec.is_load;
                    MEMTOREG    = dec.is_load;
                    state_d     = ST_RUN;
                end
            end

            default: state_d = ST_RUN;
        endcase

        // Reset asserted: every output is quiet, so an aborted MULT/MEM
        // can never leak a write-enable.
        if (!RESET) begin
            WRITEENABLE = 1'b0;
            ALUSRC      = 1'b0;
            ALUOP       = 3'b000;
            NEMUX       = 1'b0;
            BRANCH      = 2'b00;
            MEMREAD     = 1'b0;
            MEMWRITE    = 1'b0;
            MEMTOREG    = 1'b0;
            STALL       = 1'b0;
            ILLEGAL     = 1'b0;
            MEMERR      = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed testbench for multicycle_control_unit. Inputs change 1 ns after
// the rising edge; outputs are compared at the falling edge.
module tb_multicycle_control_unit;

    localparam logic [7:0] ADD   = 8'h00, SUB = 8'h01, AND_ = 8'h02, OR_ = 8'h03;
    localparam logic [7:0] MOV   = 8'h04, LOADI = 8'h05, J = 8'h06, BEQ = 8'h07;
    localparam logic [7:0] BNE   = 8'h08, MULT = 8'h09, SL = 8'h0A, UNDEF = 8'h0B;
    localparam logic [7:0] SRA   = 8'h0C, ROR = 8'h0D, LWD = 8'h0E, LWI = 8'h0F;
    localparam logic [7:0] SWD   = 8'h10, SWI = 8'h11;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [7:0] OPCODE = 8'h00;
    logic       INSTR_VALID = 1'b0;
    logic       BUSYWAIT = 1'b0;

    // Main DUT: 4-cycle multiply, 8-count memory timeout
    logic       we4, alusrc4, nemux4, mr4, mw4, m2r4, st4, ill4, me4;
    logic [2:0] aluop4;
    logic [1:0] br4;
    // Second DUT: single-cycle multiply
    logic       we1, alusrc1, nemux1, mr1, mw1, m2r1, st1, ill1, me1;
    logic [2:0] aluop1;
    logic [1:0] br1;

    int vectors     = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    multicycle_control_unit #(.OPCODE_W(8), .MULT_CYCLES(4), .MEM_TIMEOUT(8)) u_dut (
        .CLK(CLK), .RESET(RESET), .OPCODE(OPCODE), .INSTR_VALID(INSTR_VALID),
        .BUSYWAIT(BUSYWAIT), .WRITEENABLE(we4), .ALUSRC(alusrc4), .ALUOP(aluop4),
        .NEMUX(nemux4), .BRANCH(br4), .MEMREAD(mr4), .MEMWRITE(mw4), .MEMTOREG(m2r4),
        .STALL(st4), .ILLEGAL(ill4), .MEMERR(me4)
    );

    multicycle_control_unit #(.OPCODE_W(8), .MULT_CYCLES(1), .MEM_TIMEOUT(255)) u_dut1 (
        .CLK(CLK), .RESET(RESET), .OPCODE(OPCODE), .INSTR_VALID(INSTR_VALID),
        .BUSYWAIT(BUSYWAIT), .WRITEENABLE(we1), .ALUSRC(alusrc1), .ALUOP(aluop1),
        .NEMUX(nemux1), .BRANCH(br1), .MEMREAD(mr1), .MEMWRITE(mw1), .MEMTOREG(m2r1),
        .STALL(st1), .ILLEGAL(ill1), .MEMERR(me1)
    );

    // Output bundle order: WE ALUSRC ALUOP[2:0] NEMUX BRANCH[1:0] MR MW M2R STALL ILL MERR
    logic [13:0] obs4, obs1;
    assign obs4 = {we4, alusrc4, aluop4, nemux4, br4, mr4, mw4, m2r4, st4, ill4, me4};
    assign obs1 = {we1, alusrc1, aluop1, nemux1, br1, mr1, mw1, m2r1, st1, ill1, me1};

    function automatic logic [13:0] ctl(input logic we, input logic alusrc,
                                        input logic [2:0] aluop, input logic nemux,
                                        input logic [1:0] br, input logic mr, input logic mw,
                                        input logic m2r, input logic st, input logic ill,
                                        input logic me);
        return {we, alusrc, aluop, nemux, br, mr, mw, m2r, st, ill, me};
    endfunction

    // One clock: drive inputs just after the rising edge, return at the falling edge.
    task automatic apply(input logic rst, input logic valid, input logic [7:0] opc,
                         input logic busy);
        @(posedge CLK);
        #1;
        RESET       = rst;
        INSTR_VALID = valid;
        OPCODE      = opc;
        BUSYWAIT    = busy;
        @(negedge CLK);
    endtask

    task automatic check(input string tag, input logic [13:0] observed,
                         input logic [13:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    initial begin
        // Reset held with a valid ADD presented: every output must be 0.
        apply(1'b0, 1'b1, ADD, 1'b1);
        check("reset_outputs", obs4, ctl(0,0,3'b000,0,2'b00,0,0,0,0,0,0));
        apply(1'b0, 1'b0, ADD, 1'b0);

        // Idle RUN
        apply(1'b1, 1'b0, ADD, 1'b0);
        check("idle_run", obs4, ctl(0,0,3'b000,0,2'b00,0,0,0,0,0,0));

        // Single-cycle ALU and jump decodes
        apply(1'b1, 1'b1, ADD, 1'b0);
        check("add", obs4, ctl(1,1,3'b001,0,2'b00,0,0,0,0,0,0));
        apply(1'b1, 1'b1, SUB, 1'b0);
        check("sub", obs4, ctl(1,1,3'b001,1,2'b00,0,0,0,0,0,0));
        apply(1'b1, 1'b1, AND_, 1'b0);
        check("and", obs4, ctl(1,1,3'b010,0,2'b00,0,0,0,0,0,0));
        apply(1'b1, 1'b1, OR_, 1'b0);
        check("or", obs4, ctl(1,1,3'b011,0,2'b00,0,0,0,0,0,0));
        apply(1'b1, 1'b1, MOV, 1'b0);
        check("mov", obs4, ctl(1,1,3'b000,0,2'b00,0,0,0,0,0,0));
        apply(1'b1, 1'b1, LOADI, 1'b0);
        check("loadi", obs4, ctl(1,0,3'b000,0,2'b00,0,0,0,0,0,0));
        apply(1'b1, 1'b1, J, 1'b0);
        check("jump", obs4, ctl(0,0,3'b000,0,2'b01,0,0,0,0,0,0));
        apply(1'b1, 1'b1, SL, 1'b0);
        check("sl", obs4, ctl(1,0,3'b101,0,2'b00,0,0,0,0,0,0));
        apply(1'b1, 1'b1, SRA, 1'b0);
        check("sra", obs4, ctl(1,0,3'b110,0,2'b00,0,0,0,0,0,0));
        apply(1'b1, 1'b1, ROR, 1'b0);
        check("ror", obs4, ctl(1,0,3'b111,0,2'b00,0,0,0,0,0,0));

        // Back-to-back branches, never stalling
        apply(1'b1, 1'b1, BEQ, 1'b0);
        check("beq", obs4, ctl(0,1,3'b001,1,2'b10,0,0,0,0,0,0));
        apply(1'b1, 1'b1, BNE, 1'b0);
        check("bne", obs4, ctl(0,1,3'b001,1,2'b11,0,0,0,0,0,0));

        // Four-cycle multiply: ADD offered during the stall must be ignored.
        apply(1'b1, 1'b1, MULT, 1'b0);
        check("mult_issue", obs4, ctl(0,1,3'b100,0,2'b00,0,0,0,1,0,0));
        check("mult1_single", obs1, ctl(1,1,3'b100,0,2'b00,0,0,0,0,0,0));
        apply(1'b1, 1'b1, ADD, 1'b0);
        check("mult_wait2", obs4, ctl(0,1,3'b100,0,2'b00,0,0,0,1,0,0));
        apply(1'b1, 1'b1, ADD, 1'b0);
        check("mult_wait3", obs4, ctl(0,1,3'b100,0,2'b00,0,0,0,1,0,0));
        apply(1'b1, 1'b1, ADD, 1'b0);
        check("mult_done", obs4, ctl(1,1,3'b100,0,2'b00,0,0,0,0,0,0));
        apply(1'b1, 1'b0, ADD, 1'b0);
        check("mult_after", obs4, ctl(0,0,3'b000,0,2'b00,0,0,0,0,0,0));

        // Load with BUSYWAIT high for 5 MEM cycles; SUB offered meanwhile.
        apply(1'b1, 1'b1, LWD, 1'b1);
        check("lwd_issue", obs4, ctl(0,1,3'b000,0,2'b00,1,0,0,1,0,0));
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 1'b1, SUB, 1'b1);
            check("lwd_busy", obs4, ctl(0,1,3'b000,0,2'b00,1,0,0,1,0,0));
        end
        apply(1'b1, 1'b1, SUB, 1'b0);
        check("lwd_done", obs4, ctl(1,1,3'b000,0,2'b00,0,0,1,0,0,0));
        apply(1'b1, 1'b0, ADD, 1'b0);
        check("lwd_after", obs4, ctl(0,0,3'b000,0,2'b00,0,0,0,0,0,0));

        // Immediate-form load issue
        apply(1'b1, 1'b1, LWI, 1'b0);
        check("lwi_issue", obs4, ctl(0,0,3'b000,0,2'b00,1,0,0,1,0,0));
        apply(1'b1, 1'b0, ADD, 1'b0);
        check("lwi_done", obs4, ctl(1,0,3'b000,0,2'b00,0,0,1,0,0,0));

        // Direct store completing without a wait: no write-back.
        apply(1'b1, 1'b1, SWD, 1'b0);
        check("swd_issue", obs4, ctl(0,1,3'b000,0,2'b00,0,1,0,1,0,0));
        apply(1'b1, 1'b0, ADD, 1'b0);
        check("swd_done", obs4, ctl(0,1,3'b000,0,2'b00,0,0,0,0,0,0));

        // Store timeout: 9 busy MEM cycles, then MEMERR with the stall released.
        apply(1'b1, 1'b1, SWI, 1'b1);
        check("swi_issue", obs4, ctl(0,0,3'b000,0,2'b00,0,1,0,1,0,0));
        for (int i = 0; i < 9; i++) begin
            apply(1'b1, 1'b0, ADD, 1'b1);
            check("swi_busy", obs4, ctl(0,0,3'b000,0,2'b00,0,1,0,1,0,0));
        end
        apply(1'b1, 1'b0, ADD, 1'b1);
        check("swi_timeout", obs4, ctl(0,0,3'b000,0,2'b00,0,0,0,0,0,1));

        // Undefined opcode: NOP now, ILLEGAL from the next cycle, ADD still works.
        apply(1'b1, 1'b1, UNDEF, 1'b0);
        check("illegal_nop", obs4, ctl(0,0,3'b000,0,2'b00,0,0,0,0,0,1));
        apply(1'b1, 1'b1, ADD, 1'b0);
        check("illegal_then_add", obs4, ctl(1,1,3'b001,0,2'b00,0,0,0,0,1,1));

        // Reset on the 2nd multiply cycle aborts without a write and clears flags.
        apply(1'b1, 1'b1, MULT, 1'b0);
        check("rmid_issue", obs4, ctl(0,1,3'b100,0,2'b00,0,0,0,1,1,1));
        apply(1'b0, 1'b0, ADD, 1'b0);
        check("rmid_in_reset", obs4, ctl(0,0,3'b000,0,2'b00,0,0,0,0,0,0));
        apply(1'b1, 1'b0, ADD, 1'b0);
        check("rmid_after1", obs4, ctl(0,0,3'b000,0,2'b00,0,0,0,0,0,0));
        apply(1'b1, 1'b0, ADD, 1'b0);
        check("rmid_after2", obs4, ctl(0,0,3'b000,0,2'b00,0,0,0,0,0,0));
        apply(1'b1, 1'b1, ADD, 1'b0);
        check("rmid_add", obs4, ctl(1,1,3'b001,0,2'b00,0,0,0,0,0,0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
